// File: rtl/vec_player.sv
// vec_player: on-chip stimulus/response engine for a combinational core.
// Vectors and expected responses live in a small memory. Each vector is held
// on dut_in for SETTLE+1 cycles. On the last cycle of that period the core's
// response is compared against the stored expectation and folded into a MISR.
// Runs are either a single pass or repeated passes until stop is requested.
module vec_player #(
   parameter int               IN_W   = 5,
   parameter int               OUT_W  = 2,
   parameter int               DEPTH  = 32,
   parameter int               ADDR_W = 5,
   parameter int               SETTLE = 1,
   parameter int               CNT_W  = 16,
   parameter int               SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = 16'h1021,
   parameter logic [SIG_W-1:0] SEED   = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [IN_W-1:0]   wr_vec,
   input  logic [OUT_W-1:0]  wr_exp,
   input  logic              start,
   input  logic              loop_mode,
   input  logic [ADDR_W:0]   num_vec,
   input  logic              stop,
   output logic [IN_W-1:0]   dut_in,
   input  logic [OUT_W-1:0]  dut_out,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] vec_idx,
   output logic [CNT_W-1:0]  mismatch_cnt,
   output logic [SIG_W-1:0]  signature,
   output logic [15:0]       pass_cnt
);

   // One memory word holds a stimulus vector and its expected response.
   localparam int MEM_W = IN_W + OUT_W;
   // Settle counter runs 0..SETTLE; the capture happens when it reaches SETTLE.
   localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE);
   localparam logic [ADDR_W:0]   DEPTH_N     = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_MAX    = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Vector memory (no reset, contents survive rst).
   logic [MEM_W-1:0]  mem_q [DEPTH];

   // Control and output registers.
   state_t            state_q;
   logic [SET_W-1:0]  settle_q;
   logic [ADDR_W-1:0] last_q;
   logic              loop_q;
   logic              stop_q;
   logic [OUT_W-1:0]  exp_q;
   logic [IN_W-1:0]   dut_in_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] vec_idx_q;
   logic [CNT_W-1:0]  mismatch_cnt_q;
   logic [SIG_W-1:0]  signature_q;
   logic [15:0]       pass_cnt_q;

   // Next-state helpers.
   logic              wr_take_d;
   logic              start_take_d;
   logic              capture_d;
   logic              last_vec_d;
   logic              stop_seen_d;
   logic              wrap_d;
   logic [ADDR_W-1:0] rd_addr_d;
   logic [MEM_W-1:0]  rd_word_d;
   logic              mismatch_d;
   logic [CNT_W-1:0]  mismatch_cnt_d;
   logic [SIG_W-1:0]  signature_d;
   logic [ADDR_W-1:0] last_d;

   // Decode run events, the next memory address, and the captured results.
   always_comb begin
      wr_take_d    = wr_en && !start && (state_q == ST_IDLE);
      start_take_d = start && (state_q == ST_IDLE);
      capture_d    = (state_q == ST_RUN) && (settle_q == SETTLE_LAST);
      last_vec_d   = (vec_idx_q == last_q);
      // A stop arriving on the final capture edge still ends the run.
      stop_seen_d  = stop_q | stop;
      wrap_d       = capture_d && last_vec_d && loop_q && !stop_seen_d;

      // Address of the vector to load on this edge: 0 on start/wrap, else next.
      if (start_take_d || wrap_d) begin
         rd_addr_d = '0;
      end else begin
         rd_addr_d = vec_idx_q + ADDR_W'(1);
      end
      rd_word_d = mem_q[rd_addr_d];

      mismatch_d = (dut_out != exp_q);
      if (mismatch_cnt_q == {CNT_W{1'b1}}) begin
         mismatch_cnt_d = mismatch_cnt_q;
      end else begin
         mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
      end

      signature_d = {signature_q[SIG_W-2:0], 1'b0}
                  ^ (signature_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                  ^ SIG_W'(dut_out);

      // Zero or oversized vector counts mean "use the whole memory".
      if ((num_vec == '0) || (num_vec > DEPTH_N)) begin
         last_d = LAST_MAX;
      end else begin
         last_d = ADDR_W'(num_vec - (ADDR_W + 1)'(1));
      end
   end

   // Memory write port, open only while idle and not starting.
   always_ff @(posedge clk) begin
      if (wr_take_d) begin
         mem_q[wr_addr] <= {wr_vec, wr_exp};
      end
   end

   // Run FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         settle_q       <= '0;
         last_q         <= '0;
         loop_q         <= 1'b0;
         stop_q         <= 1'b0;
         exp_q          <= '0;
         dut_in_q       <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         vec_idx_q      <= '0;
         mismatch_cnt_q <= '0;
         signature_q    <= SEED;
         pass_cnt_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_take_d) begin
                  state_q             <= ST_RUN;
                  busy_q              <= 1'b1;
                  settle_q            <= '0;
                  last_q              <= last_d;
                  loop_q              <= loop_mode;
                  stop_q              <= 1'b0;
                  vec_idx_q           <= '0;
                  {dut_in_q, exp_q}   <= rd_word_d;
                  mismatch_cnt_q      <= '0;
                  signature_q         <= SEED;
                  pass_cnt_q          <= '0;
               end
            end
            ST_RUN: begin
               // Stop only matters for looping runs; it is latched until the pass ends.
               stop_q <= stop_q | (stop & loop_q);
               if (capture_d) begin
                  settle_q    <= '0;
                  signature_q <= signature_d;
                  if (mismatch_d) begin
                     mismatch_cnt_q <= mismatch_cnt_d;
                  end
                  if (!last_vec_d) begin
                     vec_idx_q         <= vec_idx_q + ADDR_W'(1);
                     {dut_in_q, exp_q} <= rd_word_d;
                  end else begin
                     pass_cnt_q <= pass_cnt_q + 16'd1;
                     if (wrap_d) begin
                        vec_idx_q         <= '0;
                        {dut_in_q, exp_q} <= rd_word_d;
                     end else begin
                        // dut_in deliberately keeps the last vector.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                     end
                  end
               end else begin
                  settle_q <= settle_q + SET_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dut_in       = dut_in_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign vec_idx      = vec_idx_q;
   assign mismatch_cnt = mismatch_cnt_q;
   assign signature    = signature_q;
   assign pass_cnt     = pass_cnt_q;

endmodule

// File: tb/tb_vec_player.sv
// Bench for vec_player: a c17 core model sits on dut_in/dut_out, a timeline
// reference model predicts every output each cycle, and a few hand-computed
// values pin the reference model itself.
module tb_vec_player;
   localparam int          P    = 2;          // SETTLE + 1
   localparam logic [15:0] POLY = 16'h1021;
   localparam logic [15:0] SEED = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [4:0]  wr_vec = '0;
   logic [1:0]  wr_exp = '0;
   logic        start = 1'b0;
   logic        loop_mode = 1'b0;
   logic [5:0]  num_vec = '0;
   logic        stop = 1'b0;

   logic [4:0]  dut_in, dut_in2;
   logic [1:0]  dut_out, dut_out2;
   logic        busy, done, busy2, done2;
   logic [4:0]  vec_idx, vec_idx2;
   logic [15:0] mismatch_cnt;
   logic [1:0]  mismatch_cnt2;
   logic [15:0] signature, signature2, pass_cnt, pass_cnt2;

   int n_tests = 0;
   int n_fail  = 0;
   bit armed   = 1'b0;

   always #5 clk = ~clk;

   // ISCAS85 c17, inputs {N1,N2,N3,N6,N7}, outputs {N22,N23}.
   function automatic logic [1:0] c17(input logic [4:0] v);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      {n1, n2, n3, n6, n7} = v;
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   assign dut_out  = c17(dut_in);
   assign dut_out2 = c17(dut_in2);

   vec_player #(.IN_W(5), .OUT_W(2), .DEPTH(32), .ADDR_W(5), .SETTLE(1),
                .CNT_W(16), .SIG_W(16), .POLY(POLY), .SEED(SEED)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_vec(wr_vec),
      .wr_exp(wr_exp), .start(start), .loop_mode(loop_mode), .num_vec(num_vec),
      .stop(stop), .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
      .vec_idx(vec_idx), .mismatch_cnt(mismatch_cnt), .signature(signature),
      .pass_cnt(pass_cnt));

   // Narrow-counter copy to exercise saturation.
   vec_player #(.IN_W(5), .OUT_W(2), .DEPTH(32), .ADDR_W(5), .SETTLE(1),
                .CNT_W(2), .SIG_W(16), .POLY(POLY), .SEED(SEED)) u_dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_vec(wr_vec),
      .wr_exp(wr_exp), .start(start), .loop_mode(loop_mode), .num_vec(num_vec),
      .stop(stop), .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
      .vec_idx(vec_idx2), .mismatch_cnt(mismatch_cnt2), .signature(signature2),
      .pass_cnt(pass_cnt2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (timeline view) ----------------
   logic [4:0]  mv [32];
   logic [1:0]  me [32];
   logic        m_busy, m_done, m_loop, m_stop;
   logic [4:0]  m_idx, m_din;
   logic [1:0]  m_resp;
   logic [15:0] m_sig;
   int          m_mis, m_mis2, m_pass, m_t, m_n, m_k;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_idx = '0; m_din = '0;
         m_sig = SEED; m_mis = 0; m_mis2 = 0; m_pass = 0; m_t = 0;
         m_loop = 1'b0; m_stop = 1'b0; m_n = 32;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1'b1; m_t = 0; m_idx = '0; m_din = mv[0];
               m_mis = 0; m_mis2 = 0; m_sig = SEED; m_pass = 0;
               m_loop = loop_mode; m_stop = 1'b0;
               m_n = (num_vec == 0 || num_vec > 32) ? 32 : int'(num_vec);
            end else if (wr_en) begin
               mv[wr_addr] = wr_vec;
               me[wr_addr] = wr_exp;
            end
         end else begin
            if (stop) m_stop = 1'b1;
            m_t++;
            if (m_t % P == 0) begin
               m_k    = m_t / P - 1;
               m_resp = c17(mv[m_k]);
               if (m_resp != me[m_k]) begin
                  if (m_mis < 65535) m_mis++;
                  if (m_mis2 < 3) m_mis2++;
               end
               m_sig = (m_sig << 1) ^ (m_sig[15] ? POLY : 16'h0000) ^ {14'd0, m_resp};
               if (m_k == m_n - 1) begin
                  m_pass = (m_pass + 1) % 65536;
                  if (m_loop && !m_stop) begin
                     m_t = 0; m_idx = '0; m_din = mv[0];
                  end else begin
                     m_busy = 1'b0; m_done = 1'b1;
                  end
               end else begin
                  m_idx = 5'(m_k + 1);
                  m_din = mv[m_k + 1];
               end
            end
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         chk("dut_in",        32'(dut_in),        32'(m_din));
         chk("busy",          32'(busy),          32'(m_busy));
         chk("done",          32'(done),          32'(m_done));
         chk("vec_idx",       32'(vec_idx),       32'(m_idx));
         chk("mismatch_cnt",  32'(mismatch_cnt),  32'(m_mis));
         chk("signature",     32'(signature),     32'(m_sig));
         chk("pass_cnt",      32'(pass_cnt),      32'(m_pass));
         chk("dut_in_c2",     32'(dut_in2),       32'(m_din));
         chk("done_c2",       32'(done2),         32'(m_done));
         chk("mismatch_c2",   32'(mismatch_cnt2), 32'(m_mis2));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic write_mem(input int a, input logic [4:0] v, input logic [1:0] e);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a[4:0]; wr_vec = v; wr_exp = e;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Starts a run and waits for done. Optional events are placed at given cycles
   // (cycle c is the one following edge c-1, the start edge being edge 0).
   task automatic run(input logic lm, input logic [5:0] n, input int stop_at,
                      input int start_at, input int wr_at, input bit wr_with_start,
                      input int bound, output int cyc, output int wraps);
      logic [4:0] prev;
      @(negedge clk);
      start = 1'b1; loop_mode = lm; num_vec = n;
      if (wr_with_start) begin
         wr_en = 1'b1; wr_addr = 5'($urandom_range(31)); wr_vec = 5'($urandom_range(31));
         wr_exp = 2'($urandom_range(3));
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      cyc = 1; wraps = 0; prev = vec_idx;
      while (!done && cyc < bound) begin
         stop  = (cyc == stop_at);
         start = (cyc == start_at);
         wr_en = (cyc == wr_at);
         wr_addr = 5'($urandom_range(31)); wr_vec = 5'($urandom_range(31));
         wr_exp = 2'($urandom_range(3));
         @(negedge clk);
         cyc++;
         if (busy && prev != 5'd0 && vec_idx == 5'd0) wraps++;
         prev = vec_idx;
      end
      stop = 1'b0; start = 1'b0; wr_en = 1'b0;
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL run_timeout: done not seen within %0d cycles", bound);
      end
      $display("[TB] run N=%0d loop=%0b cycles=%0d wraps=%0d mism=%0d sig=%04h pass=%0d",
               n, lm, cyc, wraps, mismatch_cnt, signature, pass_cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, wraps;
      rst = 1'b1;
      @(negedge clk);
      armed = 1'b1;
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_sig",    32'(signature), 32'hFFFF);
      chk("rst_dut_in", 32'(dut_in), 32'd0);
      chk("rst_pass",   32'(pass_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 32; i++)
         write_mem(i, 5'($urandom_range(31)), 2'($urandom_range(3)));
      write_mem(0, 5'b00000, 2'b00);
      write_mem(1, 5'b11111, 2'b10);

      // c17 two-vector pass
      run(1'b0, 6'd2, -1, -1, -1, 1'b0, 200, cyc, wraps);
      chk("t1_done_cycle", 32'(cyc), 32'd5);
      chk("t1_mismatch",   32'(mismatch_cnt), 32'd0);
      chk("t1_pass",       32'(pass_cnt), 32'd1);
      chk("t1_sig",        32'(signature), 32'hCF9D);

      // wrong expectation on vector 1
      write_mem(1, 5'b11111, 2'b11);
      run(1'b0, 6'd2, -1, -1, -1, 1'b0, 200, cyc, wraps);
      chk("t2_mismatch", 32'(mismatch_cnt), 32'd1);

      // single vector MISR step
      run(1'b0, 6'd1, -1, -1, -1, 1'b0, 200, cyc, wraps);
      chk("t3_sig",  32'(signature), 32'hEFDF);
      chk("t3_pass", 32'(pass_cnt), 32'd1);

      // five forced mismatches: wide counter 5, 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++)
         write_mem(i, 5'(i * 7), c17(5'(i * 7)) ^ 2'b01);
      run(1'b0, 6'd5, -1, -1, -1, 1'b0, 200, cyc, wraps);
      chk("t4_mismatch",    32'(mismatch_cnt), 32'd5);
      chk("t4_mismatch_c2", 32'(mismatch_cnt2), 32'd3);

      // loop mode, stop during pass 3
      run(1'b1, 6'd4, 19, -1, -1, 1'b0, 200, cyc, wraps);
      chk("t5_wraps",      32'(wraps), 32'd2);
      chk("t5_pass",       32'(pass_cnt), 32'd3);
      chk("t5_done_cycle", 32'(cyc), 32'd25);

      // reset at edge 5 of a 32-vector run
      @(negedge clk);
      start = 1'b1; loop_mode = 1'b0; num_vec = 6'd32;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("t6_busy",    32'(busy), 32'd0);
      chk("t6_done",    32'(done), 32'd0);
      chk("t6_idx",     32'(vec_idx), 32'd0);
      chk("t6_dut_in",  32'(dut_in), 32'd0);
      chk("t6_sig",     32'(signature), 32'hFFFF);
      chk("t6_mismatch",32'(mismatch_cnt), 32'd0);
      #2 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t6_no_done", 32'(done), 32'd0);
      end
      run(1'b0, 6'd3, -1, -1, -1, 1'b0, 200, cyc, wraps);
      chk("t6_rerun_pass", 32'(pass_cnt), 32'd1);
      chk("t6_rerun_cycle", 32'(cyc), 32'd7);

      // writes while busy, write with start, second start while busy
      run(1'b0, 6'd4, -1, 3, 2, 1'b1, 200, cyc, wraps);
      run(1'b0, 6'd4, -1, 5, 6, 1'b1, 200, cyc, wraps);
      chk("t7_done_cycle", 32'(cyc), 32'd9);

      // randomized runs
      for (int r = 0; r < 10; r++) begin
         logic lm;
         logic [5:0] n;
         for (int j = 0; j < 3; j++)
            write_mem(int'($urandom_range(31)), 5'($urandom_range(31)), 2'($urandom_range(3)));
         lm = 1'($urandom_range(1));
         n  = 6'($urandom_range(63));
         run(lm, n, lm ? int'($urandom_range(150, 1)) : -1,
             int'($urandom_range(6, 2)), int'($urandom_range(8, 1)),
             1'($urandom_range(1)), 3000, cyc, wraps);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
